// File: rtl/hazard_pkg.sv
// Purpose: shared latency constants and helpers for the hazard scoreboard.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package hazard_pkg;

    // Producer latencies in cycles until the result can be forwarded.
    localparam int LAT_ALU     = 1;
    localparam int LAT_LOAD    = 2;

    // Default width of latency fields and countdown counters.
    localparam int LAT_W_DFLT  = 3;

    // Producers slower than the scoreboard was sized for are treated as the
    // slowest supported producer instead of wrapping the counter.
    function automatic int unsigned clamp_lat(input int unsigned lat,
                                              input int unsigned max_lat);
        return (lat > max_lat) ? max_lat : lat;
    endfunction

endpackage

// File: rtl/hazard_slot.sv
// Purpose: countdown counter for one architectural register's outstanding result.
// Latency: load visible one cycle after load_i; decrements once per cycle, floor 0.
// Backpressure: none; a load always wins over the same-cycle decrement.
//
// Ports:
//   clk_i, rst_i   clock, async active-low reset
//   load_i, lat_i  load the counter with lat_i at the next edge
//   cnt_o          current counter value
//   gt1_o          counter > 1, i.e. result not yet forwardable next cycle
module hazard_slot #(
    parameter int LAT_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [LAT_W-1:0] lat_i,
    output logic [LAT_W-1:0] cnt_o,
    output logic             gt1_o
);

    logic [LAT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= lat_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - LAT_W'(1);
        end
    end

    assign cnt_o = cnt_q;
    assign gt1_o = (cnt_q > LAT_W'(1));

endmodule

// File: rtl/hazard_scoreboard.sv
// Purpose: ID-stage scoreboard; one countdown per register, drives stall/bubble controls.
// Latency: hazard -> stall_o is combinational on registered counters (0 cycles).
// Backpressure: stall_o holds PC and IF_ID and injects a bubble; stalls self-release.
//
// Optional feature macro: HAZARD_STATS_EN (saturating stall-cycle counter on
// stall_cycles_o; tied to zero when undefined).
//
// Ports:
//   clk_i, rst_i                 clock, async active-low reset
//   issue_valid_i, flush_i       instruction present in ID / being squashed
//   rs_*/rt_*                    source operand use flags and addresses
//   wr_en_i, wr_addr_i, wr_lat_i destination and its producer latency
//   stall_o, pc_write_o, ifid_write_o, ctrl_zero_o  pipeline controls
//   busy_o, pending_o            any counter non-zero / count of counters > 1
//   stall_cycles_o               stall statistics
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int MAX_LAT  = 4,
    parameter int LAT_W    = LAT_W_DFLT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              issue_valid_i,
    input  logic              rs_used_i,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic              rt_used_i,
    input  logic [ADDR_W-1:0] rt_addr_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [LAT_W-1:0]  wr_lat_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              ctrl_zero_o,
    output logic              busy_o,
    output logic [ADDR_W:0]   pending_o,
    output logic [15:0]       stall_cycles_o
);

    // Register 0 is never tracked, so the per-slot vectors start at 1.
    logic [NUM_REGS-1:1] gt1;
    logic [NUM_REGS-1:1] nz;
    logic [NUM_REGS-1:1] load;
    logic [LAT_W-1:0]    lat_clamped;
    logic                rs_hit;
    logic                rt_hit;
    logic                stall;
    logic                accept;

    assign lat_clamped = LAT_W'(clamp_lat(int'(wr_lat_i), MAX_LAT));

    // Address decode by comparison keeps out-of-range addresses and r0
    // hazard-free without indexing past the slot vector.
    always_comb begin
        rs_hit = 1'b0;
        rt_hit = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (rs_addr_i == ADDR_W'(r) && gt1[r]) rs_hit = 1'b1;
            if (rt_addr_i == ADDR_W'(r) && gt1[r]) rt_hit = 1'b1;
        end
    end

    // Hazard uses the counters before this cycle's load, so an instruction
    // reading its own destination only sees older producers.
    assign stall  = issue_valid_i & ~flush_i & ((rs_used_i & rs_hit) | (rt_used_i & rt_hit));
    assign accept = issue_valid_i & ~stall & ~flush_i;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_slot
        logic [LAT_W-1:0] cnt;

        assign load[r] = accept & wr_en_i & (wr_addr_i == ADDR_W'(r));

        hazard_slot #(
            .LAT_W (LAT_W)
        ) u_slot (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .load_i (load[r]),
            .lat_i  (lat_clamped),
            .cnt_o  (cnt),
            .gt1_o  (gt1[r])
        );

        assign nz[r] = |cnt;
    end

    always_comb begin
        pending_o = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            pending_o = pending_o + (ADDR_W+1)'(gt1[r]);
        end
    end

    assign busy_o       = |nz;
    assign stall_o      = stall;
    assign pc_write_o   = ~stall;
    assign ifid_write_o = ~stall;
    assign ctrl_zero_o  = stall | flush_i;

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
        end else if (stall && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cycles_o = stall_cnt_q;
`else
    assign stall_cycles_o = 16'h0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    localparam int NR = 32;
    localparam int AW = 5;
    localparam int ML = 4;
    localparam int LW = 3;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          issue_valid_i, rs_used_i, rt_used_i, wr_en_i, flush_i;
    logic [AW-1:0] rs_addr_i, rt_addr_i, wr_addr_i;
    logic [LW-1:0] wr_lat_i;
    logic          stall_o, pc_write_o, ifid_write_o, ctrl_zero_o, busy_o;
    logic [AW:0]   pending_o;
    logic [15:0]   stall_cycles_o;

    hazard_scoreboard #(.NUM_REGS(NR), .ADDR_W(AW), .MAX_LAT(ML), .LAT_W(LW)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .issue_valid_i  (issue_valid_i),
        .rs_used_i      (rs_used_i),
        .rs_addr_i      (rs_addr_i),
        .rt_used_i      (rt_used_i),
        .rt_addr_i      (rt_addr_i),
        .wr_en_i        (wr_en_i),
        .wr_addr_i      (wr_addr_i),
        .wr_lat_i       (wr_lat_i),
        .flush_i        (flush_i),
        .stall_o        (stall_o),
        .pc_write_o     (pc_write_o),
        .ifid_write_o   (ifid_write_o),
        .ctrl_zero_o    (ctrl_zero_o),
        .busy_o         (busy_o),
        .pending_o      (pending_o),
        .stall_cycles_o (stall_cycles_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: each register remembers the edge at which its latest
    // producer issued and that producer's (clamped) latency. The remaining
    // latency is derived from elapsed edges.
    int edges = 0;
    int m_edge [NR];
    int m_lat  [NR];
    int stall_tot = 0;

    function automatic int cnt_m(input int r);
        int v;
        if (r == 0) return 0;
        v = m_lat[r] - (edges - m_edge[r]);
        return (v < 0) ? 0 : v;
    endfunction

    function automatic logic exp_stall();
        logic haz;
        haz = (rs_used_i && cnt_m(int'(rs_addr_i)) > 1) || (rt_used_i && cnt_m(int'(rt_addr_i)) > 1);
        return issue_valid_i && !flush_i && haz;
    endfunction

    function automatic int exp_pending();
        int n = 0;
        for (int r = 1; r < NR; r++) if (cnt_m(r) > 1) n++;
        return n;
    endfunction

    function automatic logic exp_busy();
        for (int r = 1; r < NR; r++) if (cnt_m(r) > 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [10:0] exp_vec();
        logic st;
        st = exp_stall();
        return {st, ~st, ~st, st | flush_i, exp_busy(), 6'(exp_pending())};
    endfunction

    function automatic int exp_stats();
`ifdef HAZARD_STATS_EN
        return (stall_tot > 65535) ? 65535 : stall_tot;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NR; r++) begin
            m_edge[r] = 0;
            m_lat[r]  = 0;
        end
        stall_tot = 0;
    endtask

    task automatic set_in(input logic v, input logic rsu, input int rs, input logic rtu, input int rt,
                          input logic we, input int wa, input int lat, input logic fl);
        issue_valid_i = v;
        rs_used_i     = rsu;
        rs_addr_i     = AW'(rs);
        rt_used_i     = rtu;
        rt_addr_i     = AW'(rt);
        wr_en_i       = we;
        wr_addr_i     = AW'(wa);
        wr_lat_i      = LW'(lat);
        flush_i       = fl;
    endtask

    task automatic idle();
        set_in(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 0, 1'b0);
    endtask

    // Advance one clock edge; the model applies the issue the DUT should accept.
    task automatic tick();
        logic st;
        int   wa;
        st = exp_stall();
        wa = int'(wr_addr_i);
        @(posedge clk_i);
        edges++;
        if (rst_i) begin
            if (st) stall_tot++;
            if (issue_valid_i && !st && !flush_i && wr_en_i && wa != 0) begin
                m_edge[wa] = edges;
                m_lat[wa]  = (int'(wr_lat_i) > ML) ? ML : int'(wr_lat_i);
            end
        end
        #1;
    endtask

    task automatic drain();
        idle();
        repeat (ML + 1) tick();
    endtask

    task automatic test_reset();
        logic [10:0] obs;
        idle();
        #12;
        obs = {stall_o, pc_write_o, ifid_write_o, ctrl_zero_o, busy_o, pending_o};
        n_chk++;
        if (obs !== 11'b01100_000000) begin
            n_fail++; $display("FAIL reset_outputs: got %b expected %b", obs, 11'b01100_000000);
        end
        n_chk++;
        if (stall_cycles_o !== 16'h0) begin
            n_fail++; $display("FAIL reset_stats: got %0d expected 0", stall_cycles_o);
        end
        rst_i = 1'b1;
        tick();
        set_in(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 3, 4, 1'b0);
        tick();
        set_in(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 4, 3, 1'b0);
        tick();
        set_in(1'b1, 1'b1, 3, 1'b1, 4, 1'b0, 0, 0, 1'b0);
        #2;
        obs = {stall_o, pc_write_o, ifid_write_o, ctrl_zero_o, busy_o, pending_o};
        n_chk++;
        if (obs !== exp_vec() || !busy_o || pending_o !== 6'd2) begin
            n_fail++; $display("FAIL reset_preload: got %b expected %b", obs, exp_vec());
        end
        rst_i = 1'b0;
        model_reset();
        #1;
        obs = {stall_o, pc_write_o, ifid_write_o, ctrl_zero_o, busy_o, pending_o};
        n_chk++;
        if (obs !== 11'b01100_000000) begin
            n_fail++; $display("FAIL reset_midrun: got %b expected %b", obs, 11'b01100_000000);
        end
        idle();
        tick();
        rst_i = 1'b1;
        #2;
        n_chk++;
        if (busy_o !== 1'b0 || pending_o !== 6'd0) begin
            n_fail++; $display("FAIL reset_release: got busy %b pending %0d expected 0 0", busy_o, pending_o);
        end
    endtask

    task automatic test_alu_back_to_back();
        drain();
        set_in(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 3, 1, 1'b0);
        #2;
        n_chk++;
        if (stall_o !== 1'b0 || pc_write_o !== 1'b1) begin
            n_fail++; $display("FAIL alu_producer: got stall %b pc %b expected 0 1", stall_o, pc_write_o);
        end
        tick();
        set_in(1'b1, 1'b1, 3, 1'b0, 0, 1'b0, 0, 0, 1'b0);
        #2;
        n_chk++;
        if (stall_o !== 1'b0 || pc_write_o !== 1'b1 || stall_o !== exp_stall()) begin
            n_fail++; $display("FAIL alu_consumer: got stall %b pc %b expected 0 1", stall_o, pc_write_o);
        end
        tick();
    endtask

    task automatic test_load_use();
        drain();
        set_in(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 3, 2, 1'b0);
        tick();
        set_in(1'b1, 1'b0, 0, 1'b1, 3, 1'b0, 0, 0, 1'b0);
        #2;
        n_chk++;
        if (stall_o !== 1'b1 || ctrl_zero_o !== 1'b1 || ifid_write_o !== 1'b0) begin
            n_fail++; $display("FAIL load_use_stall: got stall %b ctrl_zero %b ifid %b expected 1 1 0",
                               stall_o, ctrl_zero_o, ifid_write_o);
        end
        tick();
        #2;
        n_chk++;
        if (stall_o !== 1'b0 || ctrl_zero_o !== 1'b0) begin
            n_fail++; $display("FAIL load_use_release: got stall %b ctrl_zero %b expected 0 0", stall_o, ctrl_zero_o);
        end
        tick();
    endtask

    task automatic test_long_latency();
        int lats [2] = '{4, 7};
        for (int k = 0; k < 2; k++) begin
            int  n_st;
            logic st;
            drain();
            set_in(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 7, lats[k], 1'b0);
            tick();
            set_in(1'b1, 1'b1, 7, 1'b0, 0, 1'b0, 0, 0, 1'b0);
            n_st = 0;
            for (int i = 0; i < 10; i++) begin
                #2;
                st = stall_o;
                if (st) begin
                    n_st++;
                    n_chk++;
                    if (pending_o !== 6'd1) begin
                        n_fail++; $display("FAIL long_pending_during: got %0d expected 1", pending_o);
                    end
                end
                tick();
                if (!st) break;
            end
            n_chk++;
            if (n_st != ML - 1) begin
                n_fail++; $display("FAIL long_stall_count lat %0d: got %0d expected %0d", lats[k], n_st, ML - 1);
            end
            idle();
            #2;
            n_chk++;
            if (pending_o !== 6'd0) begin
                n_fail++; $display("FAIL long_pending_after: got %0d expected 0", pending_o);
            end
        end
    endtask

    task automatic test_same_reg_and_lat0();
        drain();
        set_in(1'b1, 1'b1, 3, 1'b1, 3, 1'b1, 3, 4, 1'b0);
        #2;
        n_chk++;
        if (stall_o !== 1'b0) begin
            n_fail++; $display("FAIL same_reg_first: got %b expected 0", stall_o);
        end
        tick();
        #2;
        n_chk++;
        if (stall_o !== 1'b1) begin
            n_fail++; $display("FAIL same_reg_repeat: got %b expected 1", stall_o);
        end
        drain();
        set_in(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 9, 0, 1'b0);
        tick();
        set_in(1'b1, 1'b1, 9, 1'b1, 9, 1'b0, 0, 0, 1'b0);
        #2;
        n_chk++;
        if (stall_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL lat0: got stall %b busy %b expected 0 0", stall_o, busy_o);
        end
        tick();
    endtask

    task automatic test_r0_and_flush();
        drain();
        set_in(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 0, 4, 1'b0);
        tick();
        set_in(1'b1, 1'b1, 0, 1'b1, 0, 1'b0, 0, 0, 1'b0);
        #2;
        n_chk++;
        if (stall_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL r0_read: got stall %b busy %b expected 0 0", stall_o, busy_o);
        end
        tick();
        set_in(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 5, 3, 1'b1);
        #2;
        n_chk++;
        if (stall_o !== 1'b0 || ctrl_zero_o !== 1'b1) begin
            n_fail++; $display("FAIL flush_issue: got stall %b ctrl_zero %b expected 0 1", stall_o, ctrl_zero_o);
        end
        tick();
        set_in(1'b1, 1'b1, 5, 1'b0, 0, 1'b0, 0, 0, 1'b0);
        #2;
        n_chk++;
        if (stall_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL flush_no_load: got stall %b busy %b expected 0 0", stall_o, busy_o);
        end
        tick();
        set_in(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 5, 3, 1'b0);
        tick();
        set_in(1'b1, 1'b1, 5, 1'b0, 0, 1'b0, 0, 0, 1'b1);
        #2;
        n_chk++;
        if (stall_o !== 1'b0 || ctrl_zero_o !== 1'b1 || busy_o !== 1'b1) begin
            n_fail++; $display("FAIL flush_suppress: got stall %b ctrl_zero %b busy %b expected 0 1 1",
                               stall_o, ctrl_zero_o, busy_o);
        end
        tick();
    endtask

    task automatic test_random();
        logic [10:0] obs;
        logic [10:0] exp;
        for (int i = 0; i < 400; i++) begin
            int rs = ($urandom_range(0, 15) == 0) ? 31 : int'($urandom_range(0, 7));
            int rt = int'($urandom_range(0, 7));
            int wa = ($urandom_range(0, 15) == 0) ? 31 : int'($urandom_range(0, 7));
            set_in($urandom_range(0, 9) != 0, 1'($urandom), rs, 1'($urandom), rt,
                   1'($urandom), wa, int'($urandom_range(0, 7)), $urandom_range(0, 9) == 0);
            #2;
            obs = {stall_o, pc_write_o, ifid_write_o, ctrl_zero_o, busy_o, pending_o};
            exp = exp_vec();
            n_chk++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL random_cycle %0d: got %b expected %b", i, obs, exp);
            end
            n_chk++;
            if (int'(stall_cycles_o) != exp_stats()) begin
                n_fail++; $display("FAIL random_stats %0d: got %0d expected %0d", i, stall_cycles_o, exp_stats());
            end
            tick();
        end
    endtask

    task automatic load_use_once();
        drain();
        set_in(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 3, 2, 1'b0);
        tick();
        set_in(1'b1, 1'b0, 0, 1'b1, 3, 1'b0, 0, 0, 1'b0);
        tick();
        tick();
        idle();
        #2;
    endtask

    task automatic test_stats();
        rst_i = 1'b0;
        model_reset();
        #2;
        rst_i = 1'b1;
        repeat (3) load_use_once();
        n_chk++;
        if (int'(stall_cycles_o) != exp_stats()) begin
            n_fail++; $display("FAIL stats_three: got %0d expected %0d", stall_cycles_o, exp_stats());
        end
`ifdef HAZARD_STATS_EN
        n_chk++;
        if (stall_cycles_o !== 16'd3) begin
            n_fail++; $display("FAIL stats_three_abs: got %0d expected 3", stall_cycles_o);
        end
        force dut.stall_cnt_q = 16'hFFFF;
        #1;
        release dut.stall_cnt_q;
        stall_tot = 65535;
        load_use_once();
        n_chk++;
        if (stall_cycles_o !== 16'hFFFF) begin
            n_fail++; $display("FAIL stats_saturate: got %h expected ffff", stall_cycles_o);
        end
`endif
    endtask

    initial begin
        model_reset();
        idle();
        test_reset();
        test_alu_back_to_back();
        test_load_use();
        test_long_latency();
        test_same_reg_and_lat0();
        test_r0_and_flush();
        test_random();
        test_stats();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
